audio_track_streamer: RTL



---
 rtl/audvid_pkg.sv | 36 +++
 rtl/audio_track_streamer_if.sv | 28 ++
 rtl/sample_fifo.sv | 66 ++++++
 rtl/audio_track_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audvid_pkg.sv
// -----------------------------------------------------------------------------
// audvid_pkg
// Shared definitions for the AudVid audio path: sample and SD address widths,
// the default SD block size, the fetch FSM state encoding, and the saturating
// sample adder used by the mixer.
// No ports (package).
// -----------------------------------------------------------------------------
package audvid_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int ADDR_W      = 24;
    localparam int BLOCK_BYTES = 512;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_RECV
    } fetchState_t;

    // Adds two signed samples in SAMPLE_W+1 bits and clamps to the signed
    // SAMPLE_W range. Overflow shows up as the two top bits disagreeing.
    function automatic logic signed [SAMPLE_W-1:0] satAdd(
        input logic signed [SAMPLE_W-1:0] a,
        input logic signed [SAMPLE_W-1:0] b
    );
        logic signed [SAMPLE_W:0] sum;
        sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            satAdd = sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            satAdd = sum[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/audio_track_streamer_if.sv
// -----------------------------------------------------------------------------
// audio_track_streamer_if
// Groups the SD block-reader handshake and the DAC sample handshake.
//   master : the streamer (drives block request/address and DAC data)
//   slave  : the SD reader / I2S side (drives ack, bytes, sample requests)
// -----------------------------------------------------------------------------
interface audio_track_streamer_if;
    import audvid_pkg::*;

    logic                  SD_BlockRequest;
    logic [ADDR_W-1:0]     SD_BlockAddress;
    logic                  SD_BlockAck;
    logic [7:0]            SD_InputData;
    logic                  SD_InputDataValid;
    logic                  DAC_SampleRequest;
    logic [2*SAMPLE_W-1:0] DAC_Data;

    modport master (
        output SD_BlockRequest, SD_BlockAddress, DAC_Data,
        input  SD_BlockAck, SD_InputData, SD_InputDataValid, DAC_SampleRequest
    );

    modport slave (
        input  SD_BlockRequest, SD_BlockAddress, DAC_Data,
        output SD_BlockAck, SD_InputData, SD_InputDataValid, DAC_SampleRequest
    );

endinterface

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous DEPTH x 16-bit signed sample FIFO with show-ahead read data.
//   CLK, Reset   : clock, asynchronous active-low reset (empties the FIFO)
//   push, wrData : write one sample; dropped when full
//   pop, rdData  : rdData is the head sample; pop advances it; ignored when empty
//   clear        : empties the FIFO; wins over push/pop in the same cycle
//   count, empty, full : occupancy status
// -----------------------------------------------------------------------------
module sample_fifo
    import audvid_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic signed [SAMPLE_W-1:0] wrData,
    output logic signed [SAMPLE_W-1:0] rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic signed [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]              wrPtr;
    logic [AW-1:0]              rdPtr;
    logic                       doPush;
    logic                       doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (doPush && !clear) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/audio_track_streamer.sv
// -----------------------------------------------------------------------------
// audio_track_streamer
// Fetches SD blocks for two independently controlled audio tracks, assembles
// little-endian 16-bit samples into one FIFO per track, and on every DAC
// sample request mixes both tracks with saturation into a mono-on-both-channels
// 32-bit word.
//   CLK, Reset                 : clock, asynchronous active-low reset
//   TrackNBegin/End            : first/last SD block address (inclusive)
//   TrackNPlay/Loop            : playback enable / wrap to Begin after End
//   bus (master)               : SD block request/ack/bytes, DAC request/data
//   TrackNDone                 : one-cycle pulse when a non-looping track ends
// -----------------------------------------------------------------------------
module audio_track_streamer
    import audvid_pkg::SAMPLE_W, audvid_pkg::ADDR_W, audvid_pkg::fetchState_t,
           audvid_pkg::FETCH_IDLE, audvid_pkg::FETCH_REQ, audvid_pkg::FETCH_RECV,
           audvid_pkg::satAdd;
#(
    parameter int FIFO_DEPTH  = 512,
    parameter int BLOCK_BYTES = audvid_pkg::BLOCK_BYTES
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Track1Begin,
    input  logic [ADDR_W-1:0] Track1End,
    input  logic              Track1Play,
    input  logic              Track1Loop,
    input  logic [ADDR_W-1:0] Track2Begin,
    input  logic [ADDR_W-1:0] Track2End,
    input  logic              Track2Play,
    input  logic              Track2Loop,
    audio_track_streamer_if.master bus,
    output logic              Track1Done,
    output logic              Track2Done
);

    localparam int BLOCK_SAMPLES = BLOCK_BYTES / 2;
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int BCNT_W        = $clog2(BLOCK_BYTES);
    // A track may fetch only while a whole block still fits in its FIFO.
    localparam logic [CNT_W-1:0]  FILL_LIMIT = CNT_W'(FIFO_DEPTH - BLOCK_SAMPLES);
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(BLOCK_BYTES - 1);

    // Track inputs gathered into index-0/1 form.
    logic [1:0]        play;
    logic [1:0]        loopEn;
    logic [ADDR_W-1:0] beginAddr [2];
    logic [ADDR_W-1:0] endAddr   [2];

    assign play         = {Track2Play, Track1Play};
    assign loopEn       = {Track2Loop, Track1Loop};
    assign beginAddr[0] = Track1Begin;
    assign beginAddr[1] = Track2Begin;
    assign endAddr[0]   = Track1End;
    assign endAddr[1]   = Track2End;

    // Registered state.
    logic [1:0]            playPrev;
    logic [1:0]            active;
    logic [1:0]            fetchDone;
    logic [1:0]            discard;
    logic [1:0]            doneQ;
    logic [ADDR_W-1:0]     ptr [2];
    fetchState_t           state;
    logic                  grant;
    logic                  prefer;
    logic [BCNT_W-1:0]     byteCnt;
    logic [7:0]            lowByte;
    logic                  reqQ;
    logic [ADDR_W-1:0]     addrQ;
    logic [2*SAMPLE_W-1:0] dacQ;

    // Combinational control.
    logic [1:0]                 playRise, playFall, owner, inRecv, blockEnd;
    logic [1:0]                 eligible, push, pop, clear;
    logic [1:0]                 fifoEmpty, fifoFull;
    logic [CNT_W-1:0]           fifoCount [2];
    logic signed [SAMPLE_W-1:0] fifoRd    [2];
    logic signed [SAMPLE_W-1:0] mixIn     [2];
    logic signed [SAMPLE_W-1:0] mixSum;
    logic signed [SAMPLE_W-1:0] pushData;
    logic                       byteIn, lastByte, grantNext;

    always_comb begin
        playRise  = play & ~playPrev;
        playFall  = ~play & playPrev;
        owner     = grant ? 2'b10 : 2'b01;
        byteIn    = (state == FETCH_RECV) && bus.SD_InputDataValid;
        lastByte  = byteIn && (byteCnt == LAST_BYTE);
        pushData  = {bus.SD_InputData, lowByte};
        inRecv    = '0;
        blockEnd  = '0;
        eligible  = '0;
        push      = '0;
        pop       = '0;
        clear     = '0;
        mixIn[0]  = '0;
        mixIn[1]  = '0;
        for (int t = 0; t < 2; t++) begin
            inRecv[t]   = (state == FETCH_RECV) && owner[t];
            blockEnd[t] = lastByte && owner[t];
            eligible[t] = active[t] && play[t] && !fetchDone[t] &&
                          (fifoCount[t] <= FILL_LIMIT);
            // Odd byte completes the sample; a stopped track's bytes are dropped.
            push[t]     = byteIn && byteCnt[0] && owner[t] && !discard[t] && !fifoFull[t];
            pop[t]      = bus.DAC_SampleRequest && active[t] && !fifoEmpty[t];
            // A stop while the track's block is still arriving defers the
            // clear to the end of that block.
            clear[t]    = playRise[t] ||
                          (playFall[t] && !(inRecv[t] && !lastByte)) ||
                          (blockEnd[t] && discard[t]);
            if (active[t] && !fifoEmpty[t]) mixIn[t] = fifoRd[t];
        end
        grantNext = (&eligible) ? prefer : eligible[1];
        mixSum    = satAdd(mixIn[0], mixIn[1]);
    end

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .CLK    (CLK),
        .Reset  (Reset),
        .push   (push[0]),
        .pop    (pop[0]),
        .clear  (clear[0]),
        .wrData (pushData),
        .rdData (fifoRd[0]),
        .count  (fifoCount[0]),
        .empty  (fifoEmpty[0]),
        .full   (fifoFull[0])
    );

    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
        .CLK    (CLK),
        .Reset  (Reset),
        .push   (push[1]),
        .pop    (pop[1]),
        .clear  (clear[1]),
        .wrData (pushData),
        .rdData (fifoRd[1]),
        .count  (fifoCount[1]),
        .empty  (fifoEmpty[1]),
        .full   (fifoFull[1])
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            playPrev  <= '0;
            active    <= '0;
            fetchDone <= '0;
            discard   <= '0;
            doneQ     <= '0;
            ptr[0]    <= '0;
            ptr[1]    <= '0;
            state     <= FETCH_IDLE;
            grant     <= 1'b0;
            prefer    <= 1'b0;
            byteCnt   <= '0;
            lowByte   <= '0;
            reqQ      <= 1'b0;
            addrQ     <= '0;
            dacQ      <= '0;
        end else begin
            playPrev <= play;
            doneQ    <= '0;

            if (bus.DAC_SampleRequest) dacQ <= {mixSum, mixSum};

            // Later assignments in this loop deliberately override earlier
            // ones: a Play start wins over a same-cycle block-end update.
            for (int t = 0; t < 2; t++) begin
                if (blockEnd[t]) begin
                    if (discard[t]) begin
                        discard[t] <= 1'b0;
                    end else if (ptr[t] >= endAddr[t]) begin
                        if (loopEn[t]) ptr[t]       <= beginAddr[t];
                        else           fetchDone[t] <= 1'b1;
                    end else begin
                        ptr[t] <= ptr[t] + 1'b1;
                    end
                end

                if (playRise[t]) begin
                    ptr[t]       <= beginAddr[t];
                    active[t]    <= 1'b1;
                    fetchDone[t] <= 1'b0;
                end else if (playFall[t]) begin
                    active[t] <= 1'b0;
                    if ((state != FETCH_IDLE) && owner[t] && !lastByte) discard[t] <= 1'b1;
                end else if (active[t] && fetchDone[t] && fifoEmpty[t] && !inRecv[t]) begin
                    doneQ[t]  <= 1'b1;
                    active[t] <= 1'b0;
                end
            end

            case (state)
                FETCH_IDLE: begin
                    if (|eligible) begin
                        grant  <= grantNext;
                        prefer <= ~grantNext;
                        reqQ   <= 1'b1;
                        addrQ  <= grantNext ? ptr[1] : ptr[0];
                        state  <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (bus.SD_BlockAck) begin
                        reqQ    <= 1'b0;
                        byteCnt <= '0;
                        state   <= FETCH_RECV;
                    end
                end
                FETCH_RECV: begin
                    if (byteIn) begin
                        if (!byteCnt[0]) lowByte <= bus.SD_InputData;
                        byteCnt <= byteCnt + 1'b1;
                        if (lastByte) state <= FETCH_IDLE;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    assign bus.SD_BlockRequest = reqQ;
    assign bus.SD_BlockAddress = addrQ;
    assign bus.DAC_Data        = dacQ;
    assign Track1Done          = doneQ[0];
    assign Track2Done          = doneQ[1];

endmodule
